// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding mux
// encodings and stall counter limits.
package pipeline_hazard_ctrl_pkg;

    // Operand source selection seen by the decode-stage forwarding mux.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,  // read the register file
        FWD_E   = 2'b01,  // take the exec-stage result
        FWD_M   = 2'b10   // take the memory-stage result
    } fwd_sel_e;

    localparam int          STALL_CNT_W   = 32;
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage : pipeline_hazard_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle. The slave side is the hazard
// controller; the master side is the pipeline that consumes its decisions.
interface pipeline_hazard_ctrl_if #(
    parameter int AW   = 6,
    parameter int NSRC = 2
);
    // decode stage
    logic [NSRC*AW-1:0] rs;
    logic [NSRC-1:0]    rs_used;
    logic               dec_valid;
    logic [AW-1:0]      dec_rd;
    logic               dec_regwrite;
    logic               dec_multi;
    // exec stage
    logic [AW-1:0]      rdE;
    logic               regwriteE;
    logic               memreadE;
    // memory stage
    logic [AW-1:0]      rdM;
    logic               regwriteM;
    // multi-cycle unit writeback
    logic               wb_multi_valid;
    logic [AW-1:0]      wb_multi_rd;
    // pipeline status
    logic               branchjump_miss;
    logic               exec_fin;
    logic               memory_fin;
    // controller decisions
    logic [NSRC*2-1:0]  forward;
    logic               fetch_enable;
    logic               decode_enable;
    logic               exec_enable;
    logic               memory_enable;
    logic               write_enable;
    logic               decode_flush;
    logic               exec_flush;
    logic [31:0]        stall_cnt;

    modport slave (
        input  rs, rs_used, dec_valid, dec_rd, dec_regwrite, dec_multi,
        input  rdE, regwriteE, memreadE, rdM, regwriteM,
        input  wb_multi_valid, wb_multi_rd,
        input  branchjump_miss, exec_fin, memory_fin,
        output forward, fetch_enable, decode_enable, exec_enable,
        output memory_enable, write_enable, decode_flush, exec_flush,
        output stall_cnt
    );

    modport master (
        output rs, rs_used, dec_valid, dec_rd, dec_regwrite, dec_multi,
        output rdE, regwriteE, memreadE, rdM, regwriteM,
        output wb_multi_valid, wb_multi_rd,
        output branchjump_miss, exec_fin, memory_fin,
        input  forward, fetch_enable, decode_enable, exec_enable,
        input  memory_enable, write_enable, decode_flush, exec_flush,
        input  stall_cnt
    );

endinterface : pipeline_hazard_ctrl_if

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Register scoreboard for multi-cycle (FPU/divide) results: one pending bit
// per architectural register, plus RAW/WAW checks against the decode stage.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NREG     = 64,
    parameter int AW       = 6,
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSRC*AW-1:0] i_rs,
    input  logic [NSRC-1:0]    i_rs_used,
    input  logic [AW-1:0]      i_dec_rd,
    input  logic               i_dec_regwrite,
    input  logic               i_set_valid,
    input  logic               i_clr_valid,
    input  logic [AW-1:0]      i_clr_rd,
    output logic               o_sbstall
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic            w_raw;
    logic            w_waw;

    // Register 0 is hardwired to zero when enabled: it never becomes pending.
    function automatic logic is_zero_reg(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == {AW{1'b0}});
    endfunction

    // Decode one-hot set/clear masks for this cycle's issue and writeback.
    always_comb begin
        w_set_mask = {NREG{1'b0}};
        w_clr_mask = {NREG{1'b0}};
        if (i_set_valid && !is_zero_reg(i_dec_rd)) begin
            w_set_mask[i_dec_rd] = 1'b1;
        end else begin
            w_set_mask = {NREG{1'b0}};
        end
        if (i_clr_valid) begin
            w_clr_mask[i_clr_rd] = 1'b1;
        end else begin
            w_clr_mask = {NREG{1'b0}};
        end
    end

    // Pending bits: a same-cycle issue wins over a writeback to the same
    // register, and clearing an idle register simply leaves it at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= {NREG{1'b0}};
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    // RAW on any used source, WAW on the decode destination. While in reset
    // the pending state is treated as already cleared.
    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            w_raw = w_raw | (i_rs_used[i] && !is_zero_reg(i_rs[i*AW +: AW])
                             && r_pending[i_rs[i*AW +: AW]]);
        end
        w_waw     = i_dec_regwrite && !is_zero_reg(i_dec_rd) && r_pending[i_dec_rd];
        o_sbstall = (w_raw | w_waw) & ~rst;
    end

endmodule : hazard_scoreboard

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selection, load-use and
// scoreboard stalls, stage enables/flushes and a saturating stall counter.
// All decisions are combinational from the current inputs and pending state.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NREG     = 64,
    parameter int AW       = 6,
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    logic [NSRC*2-1:0]      w_forward;
    logic                   w_lwstall;
    logic                   w_sbstall;
    logic                   w_stall;
    logic                   w_front_enable;
    logic                   w_memory_enable;
    logic                   w_issue_multi;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Register 0 never matches a producer when it is hardwired to zero.
    function automatic logic is_zero_reg(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == {AW{1'b0}});
    endfunction

    // Per-source forwarding (exec beats memory) and load-use detection.
    // A load in exec has no result yet, so it is never forwarded from E.
    always_comb begin
        w_forward = {(NSRC*2){1'b0}};
        w_lwstall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.rs_used[i] && bus.regwriteE && !bus.memreadE
                && (bus.rdE == bus.rs[i*AW +: AW]) && !is_zero_reg(bus.rs[i*AW +: AW])) begin
                w_forward[i*2 +: 2] = FWD_E;
            end else if (bus.rs_used[i] && bus.regwriteM
                && (bus.rdM == bus.rs[i*AW +: AW]) && !is_zero_reg(bus.rs[i*AW +: AW])) begin
                w_forward[i*2 +: 2] = FWD_M;
            end else begin
                w_forward[i*2 +: 2] = FWD_REG;
            end
            w_lwstall = w_lwstall | (bus.rs_used[i] && bus.memreadE && bus.regwriteE
                                     && (bus.rdE == bus.rs[i*AW +: AW])
                                     && !is_zero_reg(bus.rs[i*AW +: AW]));
        end
    end

    // Stage enables and flushes; a branch/jump miss overrides any stall.
    always_comb begin
        w_stall         = w_lwstall | w_sbstall;
        w_memory_enable = bus.exec_fin & bus.memory_fin;
        w_front_enable  = ~w_stall & ~bus.branchjump_miss & w_memory_enable;
        // Only a decode that actually advances and is not squashed reserves a register.
        w_issue_multi   = w_front_enable & bus.dec_valid & ~bus.branchjump_miss
                          & bus.dec_multi & bus.dec_regwrite;

        bus.forward       = w_forward;
        bus.fetch_enable  = w_front_enable;
        bus.decode_enable = w_front_enable;
        bus.exec_enable   = w_front_enable;
        bus.memory_enable = w_memory_enable;
        bus.write_enable  = bus.memory_fin;
        bus.decode_flush  = bus.branchjump_miss;
        bus.exec_flush    = (bus.branchjump_miss | w_stall) & w_memory_enable;
        bus.stall_cnt     = r_stall_cnt;
    end

    hazard_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .NSRC     (NSRC),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .i_rs           (bus.rs),
        .i_rs_used      (bus.rs_used),
        .i_dec_rd       (bus.dec_rd),
        .i_dec_regwrite (bus.dec_regwrite),
        .i_set_valid    (w_issue_multi),
        .i_clr_valid    (bus.wb_multi_valid),
        .i_clr_rd       (bus.wb_multi_rd),
        .o_sbstall      (w_sbstall)
    );

    // Count stalled cycles that are not overridden by a branch/jump miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && !bus.branchjump_miss && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Each stimulus cycle pushes its
// hand-computed expectation; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 6;
    localparam int NSRC = 2;

    // {fetch, decode, exec, memory, write, decode_flush, exec_flush}
    localparam logic [6:0] C_RUN   = 7'b1111100;
    localparam logic [6:0] C_STALL = 7'b0001101;
    localparam logic [6:0] C_BJM   = 7'b0001111;

    typedef struct {
        string       nm;
        logic [3:0]  fwd;
        logic [6:0]  ctrl;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests;
    int   n_fail;

    pipeline_hazard_ctrl_if #(.AW(AW), .NSRC(NSRC)) bus ();

    pipeline_hazard_ctrl #(
        .NREG(64), .AW(AW), .NSRC(NSRC), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (bus.forward !== mon_e.fwd) begin
                n_fail++;
                $display("FAIL %s forward: got %b want %b", mon_e.nm, bus.forward, mon_e.fwd);
            end
            n_tests++;
            if ({bus.fetch_enable, bus.decode_enable, bus.exec_enable, bus.memory_enable,
                 bus.write_enable, bus.decode_flush, bus.exec_flush} !== mon_e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b want %b", mon_e.nm,
                         {bus.fetch_enable, bus.decode_enable, bus.exec_enable, bus.memory_enable,
                          bus.write_enable, bus.decode_flush, bus.exec_flush}, mon_e.ctrl);
            end
            n_tests++;
            if (bus.stall_cnt !== mon_e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d want %0d", mon_e.nm, bus.stall_cnt, mon_e.cnt);
            end
        end
    end

    task automatic idle();
        rst                 = 1'b0;
        bus.rs              = {NSRC*AW{1'b0}};
        bus.rs_used         = 2'b00;
        bus.dec_valid       = 1'b0;
        bus.dec_rd          = 6'd0;
        bus.dec_regwrite    = 1'b0;
        bus.dec_multi       = 1'b0;
        bus.rdE             = 6'd0;
        bus.regwriteE       = 1'b0;
        bus.memreadE        = 1'b0;
        bus.rdM             = 6'd0;
        bus.regwriteM       = 1'b0;
        bus.wb_multi_valid  = 1'b0;
        bus.wb_multi_rd     = 6'd0;
        bus.branchjump_miss = 1'b0;
        bus.exec_fin        = 1'b1;
        bus.memory_fin      = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input string nm, input logic [3:0] fwd, input logic [6:0] ctrl,
                        input logic [31:0] cnt);
        exp_t e;
        e.nm = nm; e.fwd = fwd; e.ctrl = ctrl; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic issue_multi(input logic [5:0] rd);
        bus.dec_valid = 1'b1; bus.dec_regwrite = 1'b1; bus.dec_multi = 1'b1; bus.dec_rd = rd;
    endtask

    task automatic load_use_src1(input logic [5:0] r);
        bus.memreadE = 1'b1; bus.regwriteE = 1'b1; bus.rdE = r;
        bus.rs = {r, 6'd0}; bus.rs_used = 2'b10;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0; n_tests = 0; n_fail = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        step(); rst = 1'b1;                                   push("rst", 4'b0000, C_RUN, 32'd0);
        step();                                               push("idle", 4'b0000, C_RUN, 32'd0);
        step(); bus.regwriteE = 1'b1; bus.rdE = 6'd5;
                bus.rs = {6'd0, 6'd5}; bus.rs_used = 2'b01;   push("fwd_e", 4'b0001, C_RUN, 32'd0);
        step(); bus.regwriteE = 1'b1; bus.rdE = 6'd5; bus.regwriteM = 1'b1; bus.rdM = 6'd5;
                bus.rs = {6'd0, 6'd5}; bus.rs_used = 2'b01;   push("fwd_e_beats_m", 4'b0001, C_RUN, 32'd0);
        step(); bus.regwriteM = 1'b1; bus.rdM = 6'd9;
                bus.rs = {6'd9, 6'd0}; bus.rs_used = 2'b10;   push("fwd_m_src1", 4'b1000, C_RUN, 32'd0);
        step(); bus.regwriteM = 1'b1; bus.rdM = 6'd9;
                bus.rs = {6'd0, 6'd9}; bus.rs_used = 2'b00;   push("fwd_unused", 4'b0000, C_RUN, 32'd0);
        step(); load_use_src1(6'd7);                          push("lwstall", 4'b0000, C_STALL, 32'd0);
        step();                                               push("after_lw", 4'b0000, C_RUN, 32'd1);
        step(); bus.regwriteE = 1'b1; bus.rdE = 6'd0; bus.regwriteM = 1'b1; bus.rdM = 6'd0;
                bus.rs = {6'd0, 6'd0}; bus.rs_used = 2'b11; issue_multi(6'd0);
                                                              push("zero_fwd", 4'b0000, C_RUN, 32'd1);
        step(); bus.memreadE = 1'b1; bus.regwriteE = 1'b1; bus.rdE = 6'd0;
                bus.rs_used = 2'b01;                          push("zero_lw", 4'b0000, C_RUN, 32'd1);
        step(); bus.rs_used = 2'b01; bus.dec_valid = 1'b1; bus.dec_regwrite = 1'b1;
                                                              push("zero_nopend", 4'b0000, C_RUN, 32'd1);
        step(); issue_multi(6'd40);                           push("issue40", 4'b0000, C_RUN, 32'd1);
        step(); bus.rs = {6'd0, 6'd40}; bus.rs_used = 2'b01;  push("raw40", 4'b0000, C_STALL, 32'd1);
        step(); bus.rs = {6'd0, 6'd40}; bus.rs_used = 2'b01;
                bus.wb_multi_valid = 1'b1; bus.wb_multi_rd = 6'd40;
                                                              push("raw40_wb", 4'b0000, C_STALL, 32'd2);
        step(); bus.rs = {6'd0, 6'd40}; bus.rs_used = 2'b01;  push("raw40_clear", 4'b0000, C_RUN, 32'd3);
        step(); issue_multi(6'd41);                           push("issue41", 4'b0000, C_RUN, 32'd3);
        step(); bus.dec_valid = 1'b1; bus.dec_regwrite = 1'b1; bus.dec_rd = 6'd41;
                                                              push("waw41", 4'b0000, C_STALL, 32'd3);
        step(); bus.dec_valid = 1'b1; bus.dec_regwrite = 1'b1; bus.dec_rd = 6'd41;
                bus.wb_multi_valid = 1'b1; bus.wb_multi_rd = 6'd41;
                                                              push("waw41_wb", 4'b0000, C_STALL, 32'd4);
        step(); bus.dec_valid = 1'b1; bus.dec_regwrite = 1'b1; bus.dec_rd = 6'd41;
                                                              push("waw41_clear", 4'b0000, C_RUN, 32'd5);
        step(); issue_multi(6'd43); bus.wb_multi_valid = 1'b1; bus.wb_multi_rd = 6'd43;
                                                              push("setclr43", 4'b0000, C_RUN, 32'd5);
        step(); bus.rs = {6'd0, 6'd43}; bus.rs_used = 2'b01;  push("raw43", 4'b0000, C_STALL, 32'd5);
        step(); bus.rs = {6'd0, 6'd43}; bus.rs_used = 2'b01;
                bus.wb_multi_valid = 1'b1; bus.wb_multi_rd = 6'd43;
                                                              push("raw43_wb", 4'b0000, C_STALL, 32'd6);
        step(); bus.rs = {6'd0, 6'd43}; bus.rs_used = 2'b01;  push("raw43_clear", 4'b0000, C_RUN, 32'd7);
        step(); bus.wb_multi_valid = 1'b1; bus.wb_multi_rd = 6'd50;
                                                              push("wb_nonpend50", 4'b0000, C_RUN, 32'd7);
        step(); bus.rs = {6'd50, 6'd50}; bus.rs_used = 2'b11; push("chk50", 4'b0000, C_RUN, 32'd7);
        step(); bus.branchjump_miss = 1'b1; issue_multi(6'd33);
                                                              push("bjm_issue33", 4'b0000, C_BJM, 32'd7);
        step(); bus.rs = {6'd0, 6'd33}; bus.rs_used = 2'b01;  push("chk33", 4'b0000, C_RUN, 32'd7);
        step(); bus.branchjump_miss = 1'b1; load_use_src1(6'd7);
                                                              push("bjm_and_lw", 4'b0000, C_BJM, 32'd7);
        step();                                               push("after_bjm_lw", 4'b0000, C_RUN, 32'd7);
        step(); bus.exec_fin = 1'b0;                          push("exec_busy", 4'b0000, 7'b0000100, 32'd7);
        step(); bus.memory_fin = 1'b0;                        push("mem_busy", 4'b0000, 7'b0000000, 32'd7);
        step(); bus.exec_fin = 1'b0; load_use_src1(6'd7);     push("lw_exec_busy", 4'b0000, 7'b0000100, 32'd7);
        step(); issue_multi(6'd40);                           push("issue40b", 4'b0000, C_RUN, 32'd8);
        step(); bus.rs = {6'd0, 6'd40}; bus.rs_used = 2'b01;  push("raw40b", 4'b0000, C_STALL, 32'd8);
        step(); rst = 1'b1; bus.rs = {6'd0, 6'd40}; bus.rs_used = 2'b01;
                                                              push("rst_pend", 4'b0000, C_RUN, 32'd9);
        step(); rst = 1'b1; load_use_src1(6'd7); bus.regwriteM = 1'b1; bus.rdM = 6'd3;
                bus.rs = {6'd7, 6'd3}; bus.rs_used = 2'b11;   push("rst_lw", 4'b0010, C_STALL, 32'd0);
        step(); bus.rs = {6'd0, 6'd40}; bus.rs_used = 2'b01;  push("post_rst", 4'b0000, C_RUN, 32'd0);

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 64, meaning architectural register count (integer plus float file).
REQ-002 SHALL have parameter AW, default 6, meaning register index width (log2 of NREG).
REQ-003 SHALL have parameter NSRC, default 2, meaning number of decode source operands checked.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning index 0 is hardwired zero (never hazards, never forwarded).
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-007 SHALL have port rs, input, NSRC*AW, meaning decode source indices.
REQ-008 SHALL have port rs_used, input, NSRC, meaning the source is actually read.
REQ-009 SHALL have port dec_valid, dec_rd, dec_regwrite, dec_multi, inputs, 1/AW/1/1, meaning the decode instruction, its destination, write flag and multi-cycle flag (FPU/div).
REQ-010 SHALL have port rdE, regwriteE, memreadE, inputs, AW/1/1, meaning exec-stage destination info.
REQ-011 SHALL have port rdM, regwriteM, inputs, AW/1, meaning memory-stage destination info.
REQ-012 SHALL have port wb_multi_valid, wb_multi_rd, inputs, 1/AW, meaning a multi-cycle result is written back this cycle.
REQ-013 SHALL have port branchjump_miss, exec_fin, memory_fin, inputs, 1 each.
REQ-014 SHALL have port forward, output, NSRC*2, meaning per source 00 regfile, 01 exec result, 10 memory result.
REQ-015 SHALL have port fetch_enable, decode_enable, exec_enable, memory_enable, write_enable, outputs, 1 each.
REQ-016 SHALL have port decode_flush, exec_flush, outputs, 1 each, meaning clear the FD / DE pipeline register.
REQ-017 SHALL have port stall_cnt, output, 32, meaning saturating count of stall cycles.

Function
REQ-018 SHALL compute forward combinationally per source: 01 if rs_used, regwriteE, ~memreadE, rdE==rs; else 10 if rs_used, regwriteM, rdM==rs; else 00; exec beats memory.
REQ-019 SHALL treat index 0 as never matching when ZERO_REG=1.
REQ-020 SHALL raise lwstall when memreadE, regwriteE and any used rs==rdE.
REQ-021 SHALL keep a pending bit per register, set when dec_multi & dec_regwrite is issued (decode_enable & dec_valid & ~branchjump_miss), cleared on wb_multi_valid at wb_multi_rd.
REQ-022 SHALL raise sbstall when any used rs is pending (RAW) or dec_regwrite and dec_rd is pending (WAW).
REQ-023 SHALL, on simultaneous set and clear of one register, leave it set.
REQ-024 SHALL ignore wb_multi_valid on a non-pending register (no error, bit stays 0).
REQ-025 SHALL drive fetch_enable = decode_enable = exec_enable = ~stall & ~branchjump_miss & exec_fin & memory_fin, with stall = lwstall | sbstall.
REQ-026 SHALL drive memory_enable = exec_fin & memory_fin and write_enable = memory_fin.
REQ-027 SHALL drive decode_flush = branchjump_miss and exec_flush = (branchjump_miss | stall) & memory_enable.
REQ-028 SHALL give branchjump_miss priority over stall: squashed decode sets no pending bit.
REQ-029 SHALL increment stall_cnt each cycle stall & ~branchjump_miss, saturating at 0xFFFFFFFF.
REQ-030 SHALL add no latency: all stall/forward/enable outputs combinational from current inputs and pending state; pending updates visible next cycle.

Reset
REQ-031 SHALL on rst clear all pending bits and stall_cnt to 0, including mid multi-cycle operation.
REQ-032 SHALL produce outputs during rst from cleared state (forward per REQ-018, stall only from lwstall).

Structure
REQ-033 SHALL place forward encodings (FWD_REG, FWD_E, FWD_M) in the shared package in def.sv.
REQ-034 SHALL use one sub-module, hazard_scoreboard, holding pending bits, set/clear logic and RAW/WAW checks.

Verification
REQ-035 SHALL cover: regwriteE=1, rdE=5, rs0=5 -> forward[0]=01; additionally rdM=5, regwriteM=1 -> still 01.
REQ-036 SHALL cover: memreadE=1, rdE=7, rs1=7 used, fins high -> fetch/decode/exec_enable=0, exec_flush=1, stall_cnt +1.
REQ-037 SHALL cover: issue multi op rd=40, next cycle rs0=40 -> sbstall; wb_multi_valid rd=40 -> stall drops the following cycle.
REQ-038 SHALL cover: rd=0 writes with rs=0 -> forward=00, no stall, no pending set.
REQ-039 SHALL cover: branchjump_miss with decode multi op rd=33 -> decode_flush=1, pending[33] stays 0.
REQ-040 SHALL cover: rst asserted with pending[40]=1 and stall_cnt=12 -> both 0 next cycle.
